// File: rtl/piso_serializer_if.sv
// rtl/piso_serializer_if.sv - load handshake and framed serial output bundle
interface piso_serializer_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] parallel_input;
    logic             load_valid;
    logic             load_ready;
    logic             serial_output;
    logic             output_valid;
    logic             first_bit;
    logic             last_bit;

    // master: the producer/link side; slave: the serializer itself
    modport master (
        output parallel_input,
        output load_valid,
        input  load_ready,
        input  serial_output,
        input  output_valid,
        input  first_bit,
        input  last_bit
    );

    modport slave (
        input  parallel_input,
        input  load_valid,
        output load_ready,
        output serial_output,
        output output_valid,
        output first_bit,
        output last_bit
    );
endinterface

// File: rtl/piso_serializer.sv
// rtl/piso_serializer.sv - parallel-in serial-out transmitter with framing strobes
module piso_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    piso_serializer_if.slave   bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] PRE_LAST_CNT = CW'(WIDTH - 2);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] shreg_q;
    logic             valid_q;
    logic             first_q;
    logic             last_q;
    logic             accept;

    assign bus.load_ready = reset & ((state_q == IDLE) | last_q);
    assign accept         = bus.load_valid & bus.load_ready;

    // The outgoing bit is the head of the shift register, so it is a flop
    // output; the register is cleared on the way to IDLE to keep the line low.
    assign bus.serial_output = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
    assign bus.output_valid  = valid_q;
    assign bus.first_bit     = first_q;
    assign bus.last_bit      = last_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shreg_q <= '0;
            valid_q <= 1'b0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
        end else if (accept) begin
            state_q <= SHIFT;
            cnt_q   <= '0;
            shreg_q <= bus.parallel_input;
            valid_q <= 1'b1;
            first_q <= 1'b1;
            last_q  <= 1'b0;
        end else if (state_q == SHIFT) begin
            if (last_q) begin
                state_q <= IDLE;
                cnt_q   <= '0;
                shreg_q <= '0;
                valid_q <= 1'b0;
                first_q <= 1'b0;
                last_q  <= 1'b0;
            end else begin
                cnt_q   <= cnt_q + 1'b1;
                shreg_q <= MSB_FIRST ? (shreg_q << 1) : (shreg_q >> 1);
                first_q <= 1'b0;
                last_q  <= (cnt_q == PRE_LAST_CNT);
            end
        end
    end
endmodule

// File: tb/tb_piso_serializer.sv
// tb/tb_piso_serializer.sv - self-checking bench for piso_serializer (both bit orders)
module tb_piso_serializer;
    localparam int W = 8;

    logic         clk   = 1'b0;
    logic         reset = 1'b1;
    logic [W-1:0] pi    = 8'hC4;
    logic         lv    = 1'b1;

    piso_serializer_if #(.WIDTH(W)) if_m ();
    piso_serializer_if #(.WIDTH(W)) if_l ();

    assign if_m.parallel_input = pi;
    assign if_m.load_valid     = lv;
    assign if_l.parallel_input = pi;
    assign if_l.load_valid     = lv;

    piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (.clk(clk), .reset(reset), .bus(if_m));
    piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (.clk(clk), .reset(reset), .bus(if_l));

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: each accepted word becomes W queued beats {bit, first, last};
    // one beat is consumed per clock, the head beat is what the line shows.
    typedef struct packed { logic b; logic f; logic l; } beat_t;
    beat_t        mq[$];
    beat_t        lq[$];
    logic [W-1:0] sent_m[$];
    logic [W-1:0] sent_l[$];
    int           acc_cnt = 0;

    function automatic logic mdl_ready();
        return reset && (mq.size() == 0 || mq[0].l);
    endfunction

    function automatic logic [4:0] exp_vec(input logic has, input beat_t bt);
        return {mdl_ready(), has ? {bt.b, 1'b1, bt.f, bt.l} : 4'b0000};
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mq.delete(); lq.delete(); sent_m.delete(); sent_l.delete();
        end else begin
            logic acc;
            acc = lv && mdl_ready();
            if (mq.size() > 0) void'(mq.pop_front());
            if (lq.size() > 0) void'(lq.pop_front());
            if (acc) begin
                acc_cnt++;
                sent_m.push_back(pi);
                sent_l.push_back(pi);
                for (int i = 0; i < W; i++) begin
                    mq.push_back('{pi[W-1-i], i == 0, i == W-1});
                    lq.push_back('{pi[i], i == 0, i == W-1});
                end
            end
        end
    end

    function automatic logic [4:0] vec_m();
        return {if_m.load_ready, if_m.serial_output, if_m.output_valid, if_m.first_bit, if_m.last_bit};
    endfunction
    function automatic logic [4:0] vec_l();
        return {if_l.load_ready, if_l.serial_output, if_l.output_valid, if_l.first_bit, if_l.last_bit};
    endfunction

    always @(negedge clk) begin
        beat_t hm, hl;
        hm = (mq.size() > 0) ? mq[0] : '0;
        hl = (lq.size() > 0) ? lq[0] : '0;
        chk("cycle_msb", {27'd0, vec_m()}, {27'd0, exp_vec(mq.size() > 0, hm)});
        chk("cycle_lsb", {27'd0, vec_l()}, {27'd0, exp_vec(lq.size() > 0, hl)});
    end

    // Behavioural SIPO receivers on the far end of each link
    logic [W-1:0] rx_m = '0;
    logic [W-1:0] rx_l = '0;
    int           rx_cnt_m = 0;
    int           rx_cnt_l = 0;

    always @(negedge clk) begin
        if (reset && if_m.output_valid) begin
            logic [W-1:0] nw;
            nw = {rx_m[W-2:0], if_m.serial_output};
            rx_m <= nw;
            if (if_m.last_bit) begin
                rx_cnt_m <= rx_cnt_m + 1;
                if (sent_m.size() == 0) chk("rx_msb_unexpected", {24'd0, nw}, 32'hFFFF_FFFF);
                else chk("rx_msb_word", {24'd0, nw}, {24'd0, sent_m.pop_front()});
            end
        end
    end

    always @(negedge clk) begin
        if (reset && if_l.output_valid) begin
            logic [W-1:0] nw;
            nw = {if_l.serial_output, rx_l[W-1:1]};
            rx_l <= nw;
            if (if_l.last_bit) begin
                rx_cnt_l <= rx_cnt_l + 1;
                if (sent_l.size() == 0) chk("rx_lsb_unexpected", {24'd0, nw}, 32'hFFFF_FFFF);
                else chk("rx_lsb_word", {24'd0, nw}, {24'd0, sent_l.pop_front()});
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (!if_m.load_ready && n < 50) begin
            tick();
            n++;
        end
        chk("wait_ready_timeout", {31'd0, if_m.load_ready}, 32'd1);
    endtask

    task automatic send(input logic [W-1:0] w);
        int a0;
        a0 = acc_cnt;
        pi = w;
        lv = 1'b1;
        for (int n = 0; n < 50; n++) begin
            tick();
            if (acc_cnt != a0) break;
        end
        chk("send_accept", acc_cnt - a0, 32'd1);
        lv = 1'b0;
    endtask

    typedef struct {
        logic [W-1:0] word;
        logic [W-1:0] seq_msb;
        logic [W-1:0] seq_lsb;
    } vec_t;

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
        vec_t         tbl[5];
        logic [W-1:0] bm, bl;
        int           a0, run, n;
        logic         prev_last;
        int           r0m, r0l;

        // transmit order written first-sent-leftmost
        tbl[0] = '{8'hC4, 8'b11000100, 8'b00100011};
        tbl[1] = '{8'h3B, 8'b00111011, 8'b11011100};
        tbl[2] = '{8'h01, 8'b00000001, 8'b10000000};
        tbl[3] = '{8'hA5, 8'b10100101, 8'b10100101};
        tbl[4] = '{8'hFF, 8'b11111111, 8'b11111111};

        // reset held with a word offered
        #1 reset = 1'b0;
        tick(); tick(); tick();
        chk("reset_msb_outputs", {27'd0, vec_m()}, 32'd0);
        chk("reset_lsb_outputs", {27'd0, vec_l()}, 32'd0);
        chk("reset_no_accept", acc_cnt, 32'd0);
        reset = 1'b1;
        lv    = 1'b0;
        #1;
        chk("release_ready", {31'd0, if_m.load_ready}, 32'd1);
        chk("release_valid", {31'd0, if_m.output_valid}, 32'd0);
        tick();

        // table: single frames in both bit orders, then back to IDLE
        for (int k = 0; k < 5; k++) begin
            wait_ready();
            send(tbl[k].word);
            pi = ~tbl[k].word;
            chk("first_bit_strobe", {31'd0, if_m.first_bit}, 32'd1);
            for (int i = 0; i < W; i++) begin
                bm = {bm[W-2:0], if_m.serial_output};
                bl = {bl[W-2:0], if_l.serial_output};
                if (i == W-1) chk("last_bit_strobe", {31'd0, if_m.last_bit}, 32'd1);
                if (i < W-1) tick();
            end
            chk("tbl_seq_msb", {24'd0, bm}, {24'd0, tbl[k].seq_msb});
            chk("tbl_seq_lsb", {24'd0, bl}, {24'd0, tbl[k].seq_lsb});
            tick();
            chk("tbl_idle_valid", {30'd0, if_m.output_valid, if_l.output_valid}, 32'd0);
            chk("tbl_idle_line", {30'd0, if_m.serial_output, if_l.serial_output}, 32'd0);
        end

        // back-to-back frames with load_valid held
        wait_ready();
        a0 = acc_cnt; pi = 8'hC4; lv = 1'b1; run = 0; prev_last = 1'b0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (acc_cnt == a0 + 1) pi = 8'h3B;
            if (acc_cnt == a0 + 2 && lv) begin
                chk("b2b_accept_on_last", {31'd0, prev_last}, 32'd1);
                lv = 1'b0;
            end
            prev_last = if_m.last_bit;
            if (if_m.output_valid) run++;
            else if (run > 0) break;
        end
        chk("b2b_run_length", run, 32'd16);
        chk("b2b_accepts", acc_cnt - a0, 32'd2);

        // load offered mid-frame must wait for the last bit
        wait_ready();
        a0 = acc_cnt;
        send(8'hC4);
        tick(); tick(); tick();
        pi = 8'hFF; lv = 1'b1;
        chk("midframe_ready", {31'd0, if_m.load_ready}, 32'd0);
        n = 0;
        while (acc_cnt != a0 + 2 && n < 20) begin
            tick();
            n++;
        end
        lv = 1'b0;
        chk("midframe_wait_edges", n, 32'd5);
        chk("midframe_new_first", {31'd0, if_m.first_bit}, 32'd1);

        // asynchronous reset in the middle of a frame
        wait_ready();
        send(8'hC4);
        tick(); tick(); tick();
        reset = 1'b0;
        #1;
        chk("abort_msb_outputs", {27'd0, vec_m()}, 32'd0);
        chk("abort_lsb_outputs", {27'd0, vec_l()}, 32'd0);
        tick(); tick();
        reset = 1'b1;
        #1;
        chk("abort_release_ready", {31'd0, if_m.load_ready}, 32'd1);
        chk("abort_release_valid", {30'd0, if_m.output_valid, if_l.output_valid}, 32'd0);
        tick();

        // random loopback into the receivers
        r0m = rx_cnt_m;
        r0l = rx_cnt_l;
        for (int k = 0; k < 10; k++) begin
            n = int'($urandom_range(0, 2));
            for (int g = 0; g < n; g++) tick();
            send(W'($urandom));
            if ($urandom_range(0, 1) == 1) pi = W'($urandom);
        end
        for (int k = 0; k < 12; k++) tick();
        chk("loop_frames_msb", rx_cnt_m - r0m, 32'd10);
        chk("loop_frames_lsb", rx_cnt_l - r0l, 32'd10);
        chk("loop_pending", sent_m.size() + sent_l.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
